// File: rtl/mmap_pkg.sv
// Shared types and helpers for the memory-map bus controller.
package mmap_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DONE  = 2'd2,
    FAULT = 2'd3
  } state_t;

  localparam int MAX_REG = 8;

  // Width of a region index; never narrower than one bit so NREG=1 still has a register.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [MAX_REG-1:0] onehot(input int idx, input int nreg);
    logic [MAX_REG-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_REG; i++) begin
      r[i] = (i == idx) && (i < nreg);
    end
    return r;
  endfunction

endpackage

// File: rtl/mmap_region_match.sv
// Inclusive unsigned address-window compare for one memory region.
module mmap_region_match #(
  parameter int N = 32
) (
  input  logic [N-1:0] base,
  input  logic [N-1:0] limit,
  input  logic [N-1:0] addr,
  output logic         hit
);

  assign hit = (addr >= base) && (addr <= limit);

endmodule

// File: rtl/mmap_bus_ctrl.sv
// Memory-map controller: region decode, wait states, write strobes and fault trapping.
// Optional MMAP_FAULT_CNT_EN adds a saturating fault_cnt output.
import mmap_pkg::*;

module mmap_bus_ctrl #(
  parameter int                      N         = 32,
  parameter int                      NREG      = 3,
  parameter int                      WAIT_W    = 4,
  parameter logic [NREG*N-1:0]       REG_BASE  = {32'h5200, 32'h4600, 32'h4000},
  parameter logic [NREG*N-1:0]       REG_LIMIT = {32'hFFFF_FFFF, 32'h5000, 32'h4400},
  parameter logic [NREG*WAIT_W-1:0]  REG_WAIT  = {4'd2, 4'd1, 4'd0},
  parameter logic [NREG-1:0]         REG_RO    = 3'b010
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req,
  input  logic [N-1:0]    DataAdr,
  input  logic            MemWrite,
  output logic            ready,
  output logic            err,
  output logic [NREG-1:0] sel,
  output logic [NREG-1:0] we,
  output logic            fault,
  output logic [N-1:0]    fault_addr,
  input  logic            fault_clr
`ifdef MMAP_FAULT_CNT_EN
  ,
  output logic [7:0]      fault_cnt
`endif
);

  localparam int IDX_W = idx_w(NREG);

  logic [NREG-1:0]   hit_vec;
  logic [IDX_W-1:0]  hit_idx;
  logic              mapped;
  logic [WAIT_W-1:0] hit_wait;
  logic              hit_ro;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0]  hit_p1, hit_d;
  logic              wr_p1, wr_d;
  logic [NREG-1:0]   acc_oh;
  logic              fault_entry;

  // Stage p0: combinational region decode of the live address
  for (genvar gi = 0; gi < NREG; gi++) begin : g_match
    mmap_region_match #(.N(N)) u_match (
      .base  (REG_BASE[gi*N +: N]),
      .limit (REG_LIMIT[gi*N +: N]),
      .addr  (DataAdr),
      .hit   (hit_vec[gi])
    );
  end

  // Scanning downward lets the lowest-indexed overlapping region win.
  always_comb begin
    hit_idx = '0;
    mapped  = 1'b0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (hit_vec[i]) begin
        hit_idx = IDX_W'(i);
        mapped  = 1'b1;
      end
    end
  end

  assign hit_wait = REG_WAIT[int'(hit_idx)*WAIT_W +: WAIT_W];
  assign hit_ro   = REG_RO[hit_idx];
  assign acc_oh   = NREG'(onehot(int'(hit_p1), NREG));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hit_d       = hit_p1;
    wr_d        = wr_p1;
    fault_entry = 1'b0;
    ready       = 1'b0;
    err         = 1'b0;
    sel         = '0;
    we          = '0;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (!mapped || (MemWrite && hit_ro)) begin
            state_d     = FAULT;
            fault_entry = 1'b1;
          end else begin
            hit_d = hit_idx;
            wr_d  = MemWrite;
            if (hit_wait == '0) begin
              state_d = DONE;
            end else begin
              cnt_d   = hit_wait;
              state_d = WAIT;
            end
          end
        end
      end
      WAIT: begin
        sel   = acc_oh;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= WAIT_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        sel     = acc_oh;
        ready   = 1'b1;
        we      = wr_p1 ? acc_oh : '0;
        state_d = IDLE;
      end
      FAULT: begin
        ready   = 1'b1;
        err     = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Stage p1: access state, wait counter and latched access attributes
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    hit_p1 <= hit_d;
    wr_p1  <= wr_d;
  end

  // A capture coinciding with fault_clr takes priority over the clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      fault      <= 1'b0;
      fault_addr <= '0;
    end else if (fault_entry && (!fault || fault_clr)) begin
      fault      <= 1'b1;
      fault_addr <= DataAdr;
    end else if (fault_clr) begin
      fault      <= 1'b0;
      fault_addr <= '0;
    end
  end

`ifdef MMAP_FAULT_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      fault_cnt <= '0;
    end else if (fault_entry && fault_clr) begin
      fault_cnt <= 8'd1;
    end else if (fault_clr) begin
      fault_cnt <= '0;
    end else if (fault_entry && (fault_cnt != 8'hFF)) begin
      fault_cnt <= fault_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mmap_bus_ctrl.sv
// Self-checking bench for mmap_bus_ctrl: directed and randomized accesses against a region-table model.
module tb_mmap_bus_ctrl;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, req, MemWrite, fault_clr;
  logic [31:0] DataAdr;
  logic        ready, err, fault;
  logic [2:0]  sel, we;
  logic [31:0] fault_addr;
`ifdef MMAP_FAULT_CNT_EN
  logic [7:0]  fault_cnt;
`endif

  logic        req2, wr2, clr2;
  logic [31:0] adr2;
  logic        ready2, err2, fault2;
  logic [1:0]  sel2, we2;
  logic [31:0] fault_addr2;
`ifdef MMAP_FAULT_CNT_EN
  logic [7:0]  fault_cnt2;
`endif

  mmap_bus_ctrl u_dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .DataAdr    (DataAdr),
    .MemWrite   (MemWrite),
    .ready      (ready),
    .err        (err),
    .sel        (sel),
    .we         (we),
    .fault      (fault),
    .fault_addr (fault_addr),
    .fault_clr  (fault_clr)
`ifdef MMAP_FAULT_CNT_EN
    ,
    .fault_cnt  (fault_cnt)
`endif
  );

  mmap_bus_ctrl #(
    .N         (32),
    .NREG      (2),
    .WAIT_W    (4),
    .REG_BASE  ({32'h80, 32'h0}),
    .REG_LIMIT ({32'h1FF, 32'hFF}),
    .REG_WAIT  ({4'd0, 4'd0}),
    .REG_RO    (2'b00)
  ) u_ovl (
    .clk        (clk),
    .reset      (reset),
    .req        (req2),
    .DataAdr    (adr2),
    .MemWrite   (wr2),
    .ready      (ready2),
    .err        (err2),
    .sel        (sel2),
    .we         (we2),
    .fault      (fault2),
    .fault_addr (fault_addr2),
    .fault_clr  (clr2)
`ifdef MMAP_FAULT_CNT_EN
    ,
    .fault_cnt  (fault_cnt2)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] m_base  [3] = '{32'h4000, 32'h4600, 32'h5200};
  logic [31:0] m_limit [3] = '{32'h4400, 32'h5000, 32'hFFFF_FFFF};
  int          m_wait  [3] = '{0, 1, 2};
  bit          m_ro    [3] = '{1'b0, 1'b1, 1'b0};
  logic [31:0] bnd     [8] = '{32'h3FFF, 32'h4000, 32'h4400, 32'h4401,
                               32'h45FF, 32'h4600, 32'h5001, 32'hFFFF_FFFF};

  bit          m_fault;
  logic [31:0] m_faddr;
  int          m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int region(input logic [31:0] a);
    for (int i = 0; i < 3; i++) begin
      if (a >= m_base[i] && a <= m_limit[i]) return i;
    end
    return -1;
  endfunction

  task automatic chk_fault_regs();
    chk("fault", {31'd0, fault}, {31'd0, m_fault});
    chk("fault_addr", fault_addr, m_faddr);
`ifdef MMAP_FAULT_CNT_EN
    chk("fault_cnt", {24'd0, fault_cnt}, m_cnt);
`endif
  endtask

  // Called at a negedge in an IDLE cycle; returns at a negedge in the following IDLE cycle.
  task automatic access(input logic [31:0] a, input bit w, input bit clr);
    int         r;
    bit         flt;
    logic [2:0] oh;
    r  = region(a);
    oh = 3'b000;
    if (r < 0) flt = 1'b1;
    else begin
      flt = w && m_ro[r];
      if (!flt) oh = 3'(1 << r);
    end
    DataAdr = a; MemWrite = w; req = 1'b1; fault_clr = clr;
    @(posedge clk);
    if (flt) begin
      if (!m_fault || clr) begin m_fault = 1'b1; m_faddr = a; end
      m_cnt = clr ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
    end else if (clr) begin
      m_fault = 1'b0; m_faddr = '0; m_cnt = 0;
    end
    @(negedge clk);
    req = 1'b0; fault_clr = 1'b0;
    if (flt) begin
      chk("flt_ready", {31'd0, ready}, 32'd1);
      chk("flt_err", {31'd0, err}, 32'd1);
      chk("flt_sel", {29'd0, sel}, 32'd0);
      chk("flt_we", {29'd0, we}, 32'd0);
    end else begin
      for (int c = 1; c <= m_wait[r]; c++) begin
        chk("wait_ready", {31'd0, ready}, 32'd0);
        chk("wait_sel", {29'd0, sel}, {29'd0, oh});
        chk("wait_we", {29'd0, we}, 32'd0);
        req = 1'($urandom_range(0, 1)); DataAdr = $urandom; MemWrite = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
      chk("done_ready", {31'd0, ready}, 32'd1);
      chk("done_err", {31'd0, err}, 32'd0);
      chk("done_sel", {29'd0, sel}, {29'd0, oh});
      chk("done_we", {29'd0, we}, w ? {29'd0, oh} : 32'd0);
    end
    chk_fault_regs();
    req = 1'($urandom_range(0, 1)); DataAdr = $urandom;
    @(negedge clk);
    chk("idle_ready", {31'd0, ready}, 32'd0);
    chk("idle_sel", {29'd0, sel}, 32'd0);
    chk("idle_we", {29'd0, we}, 32'd0);
    req = 1'b0;
  endtask

  task automatic ovl(input logic [31:0] a, input logic [1:0] exp_sel, input bit exp_err);
    adr2 = a; wr2 = 1'b1; req2 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req2 = 1'b0;
    chk("ovl_ready", {31'd0, ready2}, 32'd1);
    chk("ovl_err", {31'd0, err2}, {31'd0, exp_err});
    chk("ovl_sel", {30'd0, sel2}, {30'd0, exp_sel});
    chk("ovl_we", {30'd0, we2}, {30'd0, exp_sel});
    @(negedge clk);
    chk("ovl_idle", {31'd0, ready2}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; req = 1'b0; MemWrite = 1'b0; fault_clr = 1'b0; DataAdr = '0;
    req2 = 1'b0; wr2 = 1'b0; clr2 = 1'b0; adr2 = '0;
    m_fault = 1'b0; m_faddr = '0; m_cnt = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_sel", {29'd0, sel}, 32'd0);
    chk("rst_we", {29'd0, we}, 32'd0);
    chk_fault_regs();
    reset = 1'b0;
    @(negedge clk);

    access(32'h4100, 1'b0, 1'b0);
    access(32'h5300, 1'b1, 1'b0);
    access(32'h4800, 1'b1, 1'b0);
    access(32'h4500, 1'b0, 1'b0);
    access(32'h4500, 1'b0, 1'b1);
    access(32'h4000, 1'b0, 1'b1);

    // Reset while the ROM read sits in its wait state
    DataAdr = 32'h4700; MemWrite = 1'b0; req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    chk("rstmid_sel", {29'd0, sel}, 32'd2);
    chk("rstmid_ready", {31'd0, ready}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_fault = 1'b0; m_faddr = '0; m_cnt = 0;
    chk("rstmid_ready1", {31'd0, ready}, 32'd0);
    chk("rstmid_sel1", {29'd0, sel}, 32'd0);
    chk("rstmid_we1", {29'd0, we}, 32'd0);
    chk_fault_regs();
    @(negedge clk);
    chk("rstmid_ready2", {31'd0, ready}, 32'd0);
    chk("rstmid_we2", {29'd0, we}, 32'd0);
    access(32'h4000, 1'b0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      access(bnd[i], 1'($urandom_range(0, 1)), 1'b0);
    end
    access(32'h5000, 1'b1, 1'b0);
    access(32'h4600, 1'b0, 1'b0);

    ovl(32'h90, 2'b01, 1'b0);
    ovl(32'h100, 2'b10, 1'b0);
    ovl(32'h200, 2'b00, 1'b1);
    chk("ovl_fault", {31'd0, fault2}, 32'd1);
    chk("ovl_faddr", fault_addr2, 32'h200);

    for (int i = 0; i < 80; i++) begin
      logic [31:0] a;
      case ($urandom_range(0, 3))
        0:       a = $urandom;
        1:       a = 32'h3F00 + 32'($urandom_range(0, 32'h1600));
        2:       a = bnd[$urandom_range(0, 7)];
        default: a = 32'h5200 + 32'($urandom_range(0, 255));
      endcase
      access(a, 1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mmap_bus_ctrl.md
Name: mmap_bus_ctrl

Overview:
Parametrised memory-map controller for the ARM data bus. Decodes each CPU data access against NREG configurable address regions and drives a one-hot data-mux select. Generates a per-region single-cycle write strobe after a per-region wait-state count, and returns a ready/err handshake. Unmapped accesses and writes to read-only regions are trapped, with the faulting address captured. Sits between the core's DataAdr/MemWrite outputs and the RAM, ROM and timer peripherals.

Parameters:
N, 32, address width
NREG, 3, number of regions (1..8)
WAIT_W, 4, wait-state counter width
REG_BASE, {32'h5200,32'h4600,32'h4000}, packed NREG*N region base addresses, inclusive; region 0 in the LSBs
REG_LIMIT, {32'hFFFF_FFFF,32'h5000,32'h4400}, packed NREG*N region limit addresses, inclusive
REG_WAIT, {4'd2,4'd1,4'd0}, packed NREG*WAIT_W wait states per region
REG_RO, 3'b010, per-region read-only flag (bit 1 = ROM)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
req  in  1  access request; sampled only in IDLE
DataAdr  in  N  access address
MemWrite  in  1  1 = write, 0 = read
ready  out  1  one-cycle access-complete pulse
err  out  1  qualifies ready; access faulted
sel  out  NREG  one-hot region select; drives the read-data mux
we  out  NREG  one-hot write strobe; high only in the ready cycle
fault  out  1  sticky fault flag
fault_addr  out  N  address of the first unacknowledged fault
fault_clr  in  1  clears fault and fault_addr

Behaviour:
- Clock and reset: single clock clk. reset is synchronous, active-high, and overrides all other inputs.
- Reset values: state=IDLE; ready, err, fault = 0; sel, we = 0; fault_addr = 0; wait counter = 0.
- Region match: a region matches when REG_BASE[i] <= DataAdr <= REG_LIMIT[i], using unsigned compares. If regions overlap, the lowest index wins. No match means unmapped.
- FSM states: IDLE, WAIT, DONE, FAULT.
- IDLE, req=0: stay in IDLE.
- IDLE, req=1, mapped, and not (MemWrite and REG_RO[hit]):
  - latch address, write flag and hit index;
  - sel = onehot(hit) from the next cycle;
  - if REG_WAIT[hit]=0, go to DONE; otherwise load the counter with REG_WAIT[hit] and go to WAIT.
- IDLE, req=1, unmapped or RO-write: go to FAULT. sel stays 0.
- WAIT: decrement the counter each cycle; go to DONE when the counter reaches 1.
- DONE: ready=1 for one cycle. we=onehot(hit) if the latched write flag is set. Return to IDLE, and sel drops to 0 on the next cycle.
- FAULT: ready=1 and err=1 for one cycle, we=0, then return to IDLE.
- Latency from the req sample to ready is REG_WAIT+1 cycles; a fault takes 1 cycle.
- req is ignored outside IDLE. Back-to-back accesses are possible: req may be high in the cycle after ready, i.e. one IDLE cycle between accesses.
- Sticky fault register: on entry to FAULT, if fault=0, set fault=1 and fault_addr=DataAdr. Later faults do not overwrite fault_addr.
- fault_clr: clears fault and fault_addr. If a fault is captured in the same cycle as fault_clr, the capture wins.
- Reset mid-access (WAIT or DONE): return to IDLE; no we or ready pulse is produced.
- No output is ever driven to Z; there is no X or Z propagation on unmapped addresses.

Optional Feature:
MMAP_FAULT_CNT_EN
- Defined: adds output fault_cnt [7:0], which counts FAULT entries. It saturates at 8'hFF, clears on reset and on fault_clr, and increments even while fault=1. Capture in the same cycle as fault_clr leaves fault_cnt=1.
- Undefined: port and logic absent; the rest of the behaviour is unchanged.

Decomposition:
- Package mmap_pkg:
  - state_t enum {IDLE, WAIT, DONE, FAULT};
  - MAX_REG=8;
  - function clog2-based index width;
  - helper function onehot(idx, NREG).
- Sub-module mmap_region_match: combinational compare of one region (base, limit, addr -> hit). Instantiated NREG times with a generate loop; a priority encoder in the top level.

Test Plan:
- Read 0x4100, req for 1 cycle -> sel=3'b001 from the next cycle, ready at +1 cycle, we=0, err=0.
- Write 0x5300 -> sel=3'b100, ready and we=3'b100 together at +3 cycles (wait=2), we high exactly 1 cycle.
- Write 0x4800 (ROM, RO) -> ready=1, err=1 at +1, we=0, fault=1, fault_addr=0x4800. Then read 0x4500 (unmapped) -> err=1, fault_addr still 0x4800.
- Assert fault_clr in the same cycle as a new fault at 0x4500 -> fault=1, fault_addr=0x4500. With MMAP_FAULT_CNT_EN, fault_cnt=1.
- Accept read 0x4700, assert reset in the WAIT cycle -> no ready pulse; sel=0, state IDLE next cycle. Next req at 0x4000 completes normally at +1.
- Regions overlap, with NREG=2, region 0 = 0x0-0xFF and region 1 = 0x80-0x1FF: access 0x90 -> sel=2'b01.
